uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver with 16× (configurable) oversampling, a 2-flop input synchroniser and 3-sample majority voting. Data width, parity mode and stop-bit count are set by parameters. Received words are held on a valid/ready output port, with parity, framing and overrun status. It sits between the board RX pin and the command/RPN front end and runs from the single system clock.

## Interface
- CLK_FREQ, 125_000_000: clk frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- OVERSAMPLE, 16: ticks per bit; even, ≥ 8.
- DATA_BITS, 8: payload width, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- rx_in  input  1  serial line, idle high, asynchronous to clk.
- out  output  DATA_BITS  received word; bit 0 is the first data bit on the line.
- out_valid  output  1  word available; held until accepted.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- parity_err  output  1  parity mismatch for the word on out; always 0 if PARITY = 0.
- frame_err  output  1  at least one stop bit of the word on out sampled 0.
- overrun  output  1  sticky; set when a frame was discarded because out was still full.

## Operation
- Tick generator: DIV = (CLK_FREQ + BAUD·OVERSAMPLE/2) / (BAUD·OVERSAMPLE), rounded to nearest. It is a free-running counter that emits a 1-cycle tick every DIV clocks. DIV < 1 is an elaboration error. The defaults give DIV = 68.
- Synchroniser: two flops on rx_in, both reset to 1, giving rx_s. All decisions use rx_s, and only on tick cycles.
- Bit sampling: a tick counter s runs 0..OVERSAMPLE-1 within each bit. The bit value is the majority of rx_s at s = OS/2-1, OS/2 and OS/2+1. The decision is made at s = OS/2+1.
- The state machine has six states: IDLE, START, DATA, PARITY, STOP, and IDLE-unarmed.
- IDLE-unarmed → IDLE on the first tick with rx_s = 1. This is the reset state and the state after any frame with frame_err.
- IDLE: a tick with rx_s = 0 → START, with s = 0 on that tick (tick 0 of the start bit).
- START: a majority of 1 is a false start → IDLE, with no output and no flags. A majority of 0 → DATA.
- DATA: DATA_BITS bits, LSB first, shifted into the data register → PARITY if PARITY ≠ 0, else → STOP.
- PARITY: the received bit is checked against odd or even parity over the data bits, and the result is latched as a pending error.
- STOP: STOP_BITS bits are sampled; any 0 sets pending frame_err. After the decision on the last stop bit the frame completes, and the FSM goes to IDLE (or to IDLE-unarmed if frame_err) on that same tick. This resynchronises at mid-stop-bit.
- Frame completion when out_valid = 0, or out_valid && out_ready in the same cycle: load out, parity_err and frame_err, and set out_valid = 1.
- Frame completion when out_valid = 1 && !out_ready: the new frame is discarded, out and its flags are unchanged, and overrun is set to 1.
- Handshake without a completion: out_valid → 0 and overrun → 0. out, parity_err and frame_err keep their values.
- overrun is cleared only by a handshake. If a handshake and an overrun-causing completion coincide, the new word is loaded instead, so no overrun occurs.

## Timing
- Reset values (async assert): out = 0, out_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, FSM = IDLE-unarmed, tick counter = 0, synchroniser = 1. Deassertion mid-frame discards the partial frame.
- Input latency is 2 clk (synchroniser) plus up to DIV clk (tick phase) before a start edge is seen.
- out_valid rises on the clk edge after the tick carrying the final stop-bit decision. That is the registered update: visible in the cycle after that edge.
- out, the error flags and out_valid are stable while out_valid = 1 && !out_ready.
- A glitch lasting fewer than OS/2-1 ticks cannot produce a frame.
- Back-to-back frames with no idle gap are received without loss, provided the consumer accepts each word within 1/2 bit time.

## Test plan
Parameters for all scenarios: CLK_FREQ = 1_843_200, BAUD = 115200, OVERSAMPLE = 16, giving DIV = 1. Each bit is 16 clk.
1. 8N1, send 0x55 with out_ready = 1 → one handshake with out = 0x55, parity_err = 0, frame_err = 0.
2. PARITY = 2 (8E1), send 0xA3 with parity bit 0 (correct is 0) → no error. Resend with parity bit 1 → out = 0xA3, parity_err = 1.
3. 8N1, send 0x00 with stop bit 0, then hold the line low for 20 bit times → exactly one word with frame_err = 1. No further frames until the line returns high; a subsequent 0x3C is received correctly.
4. Drive a low pulse of 5 clk, then idle → out_valid stays 0 and the FSM returns to IDLE.
5. Send 0x11 then 0x22 back-to-back with out_ready = 0 → out = 0x11 and overrun = 1. Pulse out_ready → out_valid = 0 and overrun = 0.
6. Assert rst_n = 0 during data bit 3 of a frame → all outputs 0 immediately. After release, 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// Receive-side word port of uart_rx_cfg: a held word with its status flags
// and a valid/ready handshake toward the consumer.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output out, out_valid, parity_err, frame_err, overrun,
        input  out_ready
    );

    modport slave (
        input  out, out_valid, parity_err, frame_err, overrun,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver: synchronised input, 3-sample majority per bit,
// configurable data/parity/stop framing, one-word holding register with status.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 125_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_in,
    uart_rx_cfg_if.master      rx_if
);
    localparam int DIV   = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W   = $clog2(OVERSAMPLE);
    localparam int BC_W  = 4;

    localparam logic [2:0] ST_UNARMED = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_START   = 3'd2;
    localparam logic [2:0] ST_DATA    = 3'd3;
    localparam logic [2:0] ST_PARITY  = 3'd4;
    localparam logic [2:0] ST_STOP    = 3'd5;

    localparam logic [S_W-1:0] S_LO   = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2);
    localparam logic [S_W-1:0] S_DEC  = S_W'(OVERSAMPLE / 2 + 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic           PAR_ODD = (PARITY == 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_rx_cfg: clock too slow for BAUD*OVERSAMPLE");
        end
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
            $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 sync1_q, sync2_q;
    logic [2:0]           state_q, state_d;
    logic [S_W-1:0]       s_q, s_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 ferr_pend_q, ferr_pend_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic tick, rx_s, busy, decide, maj, complete, ferr_now, hs;

    assign tick   = (div_cnt_q == DIV_W'(DIV - 1));
    assign rx_s   = sync2_q;
    assign busy   = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);
    assign decide = tick && busy && (s_q == S_DEC);
    // The third sample is taken live on the decision tick.
    assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign hs     = out_valid_q && rx_if.out_ready;

    always_comb begin
        div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
        state_d      = state_q;
        s_d          = s_q;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        perr_pend_d  = perr_pend_q;
        ferr_pend_d  = ferr_pend_q;
        complete     = 1'b0;
        ferr_now     = 1'b0;

        if (tick && busy) begin
            s_d = (s_q == S_LAST) ? '0 : s_q + S_W'(1);
            if (s_q == S_LO)  samp_d[0] = rx_s;
            if (s_q == S_MID) samp_d[1] = rx_s;
        end

        if (tick) begin
            case (state_q)
                ST_UNARMED: if (rx_s) state_d = ST_IDLE;
                ST_IDLE: begin
                    if (!rx_s) begin
                        // This tick is s = 0 of the start bit.
                        state_d     = ST_START;
                        s_d         = S_W'(1);
                        bit_cnt_d   = '0;
                        perr_pend_d = 1'b0;
                        ferr_pend_d = 1'b0;
                    end
                end
                ST_START: if (decide) state_d = maj ? ST_IDLE : ST_DATA;
                ST_DATA: begin
                    if (decide) begin
                        shift_d = {maj, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BC_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide) begin
                        perr_pend_d = ((^shift_q) ^ maj) != PAR_ODD;
                        state_d     = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (decide) begin
                        ferr_now    = ferr_pend_q | ~maj;
                        ferr_pend_d = ferr_now;
                        if (bit_cnt_q == BC_W'(STOP_BITS - 1)) begin
                            complete = 1'b1;
                            state_d  = ferr_now ? ST_UNARMED : ST_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BC_W'(1);
                        end
                    end
                end
                default: state_d = ST_UNARMED;
            endcase
        end
    end

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        if (complete && (!out_valid_q || rx_if.out_ready)) begin
            out_d        = shift_q;
            parity_err_d = perr_pend_q;
            frame_err_d  = ferr_now;
            out_valid_d  = 1'b1;
            if (hs) overrun_d = 1'b0;
        end else if (complete) begin
            overrun_d = 1'b1;
        end else if (hs) begin
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= ST_UNARMED;
            s_q          <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= 2'b11;
            shift_q      <= '0;
            perr_pend_q  <= 1'b0;
            ferr_pend_q  <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            sync1_q      <= rx_in;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            s_q          <= s_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            perr_pend_q  <= perr_pend_d;
            ferr_pend_q  <= ferr_pend_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_if.out        = out_q;
    assign rx_if.out_valid  = out_valid_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and an 8E1 receiver at DIV = 1 (16 clk per bit),
// directed scenarios followed by random frames checked against a frame-level model.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic ready_a = 1'b1;
    logic ready_b = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_b ();
    assign if_a.out_ready = ready_a;
    assign if_b.out_ready = ready_b;

    uart_rx_cfg #(.CLK_FREQ(1_843_200), .BAUD(115200), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_8n1 (.clk(clk), .rst_n(rst_n), .rx_in(rx_a), .rx_if(if_a));

    uart_rx_cfg #(.CLK_FREQ(1_843_200), .BAUD(115200), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u_8e1 (.clk(clk), .rst_n(rst_n), .rx_in(rx_b), .rx_if(if_b));

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    word_t qa[$];
    word_t qb[$];

    // Record every accepted word; the handshake completes on the next posedge.
    always @(negedge clk) begin
        if (rst_n && if_a.out_valid && if_a.out_ready)
            qa.push_back('{d: if_a.out, pe: if_a.parity_err, fe: if_a.frame_err});
        if (rst_n && if_b.out_valid && if_b.out_ready)
            qb.push_back('{d: if_b.out, pe: if_b.parity_err, fe: if_b.frame_err});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input bit which, input logic v);
        if (which) rx_b = v; else rx_a = v;
        cyc(16);
    endtask

    // Port B is the 8E1 receiver, so only it gets a parity bit on the line.
    task automatic send_frame(input bit which, input logic [7:0] d, input logic pbit,
                              input logic stop);
        send_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(which, d[i]);
        if (which) send_bit(which, pbit);
        send_bit(which, stop);
    endtask

    // Even parity: the nine line bits must contain an even number of ones.
    function automatic logic model_perr(input bit which, input logic [7:0] d, input logic p);
        if (!which) return 1'b0;
        return ($countones({d, p}) % 2) != 0;
    endfunction

    task automatic expect_word(input bit which, input string tag, input logic [7:0] d,
                               input logic pe, input logic fe);
        word_t w;
        int    waited = 0;
        logic  got;
        got = which ? (qb.size() != 0) : (qa.size() != 0);
        while (!got && waited < 64) begin
            cyc(1);
            waited++;
            got = which ? (qb.size() != 0) : (qa.size() != 0);
        end
        chk({tag, "_arrived"}, {31'd0, got}, 32'd1);
        if (got) begin
            w = which ? qb.pop_front() : qa.pop_front();
            $display("[TB] %s: out=%02h parity_err=%0b frame_err=%0b (want %02h %0b %0b)",
                     tag, w.d, w.pe, w.fe, d, pe, fe);
            chk({tag, "_data"}, {24'd0, w.d}, {24'd0, d});
            chk({tag, "_perr"}, {31'd0, w.pe}, {31'd0, pe});
            chk({tag, "_ferr"}, {31'd0, w.fe}, {31'd0, fe});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       saw_valid;
        logic [7:0] d;
        logic       p, stop, which;
        int         gap;

        // Reset values while rst_n is held low
        cyc(3);
        chk("rst_out", {24'd0, if_a.out}, 32'd0);
        chk("rst_valid", {31'd0, if_a.out_valid}, 32'd0);
        chk("rst_perr", {31'd0, if_a.parity_err}, 32'd0);
        chk("rst_ferr", {31'd0, if_a.frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, if_a.overrun}, 32'd0);
        chk("rst_valid_b", {31'd0, if_b.out_valid}, 32'd0);
        rst_n = 1'b1;
        cyc(20);

        // 8N1 basic word
        send_frame(1'b0, 8'h55, 1'b0, 1'b1);
        expect_word(1'b0, "s1_55", 8'h55, 1'b0, 1'b0);
        cyc(32);
        chk("s1_no_extra", qa.size(), 32'd0);

        // 8E1 correct then wrong parity
        send_frame(1'b1, 8'hA3, 1'b0, 1'b1);
        expect_word(1'b1, "s2_good", 8'hA3, 1'b0, 1'b0);
        send_frame(1'b1, 8'hA3, 1'b1, 1'b1);
        expect_word(1'b1, "s2_bad", 8'hA3, 1'b1, 1'b0);

        // Framing error then a long break: exactly one word, no re-trigger
        send_frame(1'b0, 8'h00, 1'b0, 1'b0);
        rx_a = 1'b0;
        cyc(16 * 20);
        expect_word(1'b0, "s3_break", 8'h00, 1'b0, 1'b1);
        chk("s3_single", qa.size(), 32'd0);
        chk("s3_valid_low", {31'd0, if_a.out_valid}, 32'd0);
        rx_a = 1'b1;
        cyc(32);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
        expect_word(1'b0, "s3_3c", 8'h3C, 1'b0, 1'b0);

        // Short glitch must not produce a frame
        rx_a = 1'b0;
        cyc(5);
        rx_a = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 48; i++) begin
            cyc(1);
            if (if_a.out_valid) saw_valid = 1'b1;
        end
        chk("s4_glitch", {31'd0, saw_valid}, 32'd0);
        send_frame(1'b0, 8'h96, 1'b0, 1'b1);
        expect_word(1'b0, "s4_after", 8'h96, 1'b0, 1'b0);

        // Back-to-back frames while the consumer stalls
        ready_a = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b1);
        cyc(4);
        chk("s5_out", {24'd0, if_a.out}, 32'h11);
        chk("s5_valid", {31'd0, if_a.out_valid}, 32'd1);
        chk("s5_ovr", {31'd0, if_a.overrun}, 32'd1);
        ready_a = 1'b1;
        cyc(1);
        ready_a = 1'b0;
        chk("s5_valid_clr", {31'd0, if_a.out_valid}, 32'd0);
        chk("s5_ovr_clr", {31'd0, if_a.overrun}, 32'd0);
        expect_word(1'b0, "s5_taken", 8'h11, 1'b0, 1'b0);

        // Reset during data bit 3 while a word is held
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
        cyc(2);
        chk("s6_held", {24'd0, if_a.out}, 32'h5A);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        rx_a = 1'b0;
        cyc(8);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_out", {24'd0, if_a.out}, 32'd0);
        chk("s6_valid", {31'd0, if_a.out_valid}, 32'd0);
        chk("s6_perr", {31'd0, if_a.parity_err}, 32'd0);
        chk("s6_ferr", {31'd0, if_a.frame_err}, 32'd0);
        chk("s6_ovr", {31'd0, if_a.overrun}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        rx_a = 1'b1;
        ready_a = 1'b1;
        cyc(40);
        chk("s6_no_word", qa.size(), 32'd0);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1);
        expect_word(1'b0, "s6_c3", 8'hC3, 1'b0, 1'b0);

        // Random frames on both receivers
        for (int n = 0; n < 24; n++) begin
            which = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            p     = 1'($urandom_range(0, 1));
            stop  = ($urandom_range(0, 5) != 0);
            send_frame(which, d, p, stop);
            expect_word(which, $sformatf("rnd%0d", n), d, model_perr(which, d, p), ~stop);
            gap = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            for (int g = 0; g < gap; g++) send_bit(which, 1'b1);
        end
        cyc(32);
        chk("rnd_drain_a", qa.size(), 32'd0);
        chk("rnd_drain_b", qb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
